shooter_controller: RTL



---
 rtl/shooter_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/shooter_controller.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/shooter_pkg.sv
// Shared definitions for the shooter sprite path (controller and color_mapper).
// Contents: facing-direction enum, HID keycodes for WASD, blue floor bounds and sprite size.
package shooter_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // Inclusive pixel bounds of the blue floor region.
  localparam int unsigned FLOOR_X_LO = 32;
  localparam int unsigned FLOOR_X_HI = 607;
  localparam int unsigned FLOOR_Y_LO = 62;
  localparam int unsigned FLOOR_Y_HI = 447;

  localparam int unsigned SPRITE_W = 32;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous strobe, followed by a rising-edge detector.
// Ports:
//   clk_i    - destination clock
//   rst_ni   - asynchronous active-low reset
//   async_i  - asynchronous input level
//   pulse_o  - one-cycle pulse on each synchronized 0->1 transition
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule

// File: rtl/shooter_controller.sv
// Shooter sprite controller: once per video frame samples the keycode, updates facing,
// moves the 32x32 sprite by STEP clamped to the floor, and advances a walk-animation index.
// Ports:
//   Clk, Reset_n - system clock, asynchronous active-low reset
//   frame_clk    - VGA vsync (asynchronous), rising edge starts a frame update
//   keycode      - USB HID keycode, 0x00 = no key
//   ShooterX/Y   - sprite upper-left pixel
//   ShooterDir   - facing (00 up, 01 right, 10 down, 11 left)
//   moving       - last update decoded a movement key
//   anim_idx     - walk-animation frame index
module shooter_controller
  import shooter_pkg::*;
#(
  parameter int unsigned STEP     = 4,
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned X_MIN    = FLOOR_X_LO,
  parameter int unsigned X_MAX    = FLOOR_X_HI - SPRITE_W + 1,
  parameter int unsigned Y_MIN    = FLOOR_Y_LO,
  parameter int unsigned Y_MAX    = FLOOR_Y_HI - SPRITE_W + 1,
  parameter int unsigned X_SPAWN  = 304,
  parameter int unsigned Y_SPAWN  = 239
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] ShooterX,
  output logic [9:0] ShooterY,
  output logic [1:0] ShooterDir,
  output logic       moving,
  output logic [1:0] anim_idx
);

  localparam int unsigned AnimW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AnimW-1:0] AnimLast = AnimW'(ANIM_DIV - 1);

  // 11-bit signed so that MIN - STEP stays negative instead of wrapping.
  localparam logic signed [10:0] StepS = 11'(STEP);
  localparam logic signed [10:0] XMinS = 11'(X_MIN);
  localparam logic signed [10:0] XMaxS = 11'(X_MAX);
  localparam logic signed [10:0] YMinS = 11'(Y_MIN);
  localparam logic signed [10:0] YMaxS = 11'(Y_MAX);

  typedef enum logic [1:0] {StIdle, StSample, StUpdate} state_e;

  state_e           state_q;
  logic [7:0]       key_q;
  logic [9:0]       x_q, y_q;
  dir_t             dir_q;
  logic             moving_q;
  logic [1:0]       anim_q;
  logic [AnimW-1:0] anim_cnt_q;
  logic             frame_tick;

  sync_edge_detect u_frame_sync (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .async_i(frame_clk),
    .pulse_o(frame_tick)
  );

  logic                key_valid;
  dir_t                key_dir;
  logic signed [10:0]  dx, dy, x_sum, y_sum;
  logic [9:0]          x_d, y_d;

  always_comb begin
    key_valid = 1'b1;
    key_dir   = dir_q;
    dx        = '0;
    dy        = '0;
    case (key_q)
      KEY_W: begin key_dir = DIR_UP;    dy = -StepS; end
      KEY_D: begin key_dir = DIR_RIGHT; dx =  StepS; end
      KEY_S: begin key_dir = DIR_DOWN;  dy =  StepS; end
      KEY_A: begin key_dir = DIR_LEFT;  dx = -StepS; end
      default: key_valid = 1'b0;
    endcase

    x_sum = $signed({1'b0, x_q}) + dx;
    y_sum = $signed({1'b0, y_q}) + dy;

    if (x_sum < XMinS)      x_d = 10'(X_MIN);
    else if (x_sum > XMaxS) x_d = 10'(X_MAX);
    else                    x_d = x_sum[9:0];

    if (y_sum < YMinS)      y_d = 10'(Y_MIN);
    else if (y_sum > YMaxS) y_d = 10'(Y_MAX);
    else                    y_d = y_sum[9:0];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      key_q      <= '0;
      x_q        <= 10'(X_SPAWN);
      y_q        <= 10'(Y_SPAWN);
      dir_q      <= DIR_UP;
      moving_q   <= 1'b0;
      anim_q     <= '0;
      anim_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (frame_tick) state_q <= StSample;
        end
        StSample: begin
          key_q   <= keycode;
          state_q <= StUpdate;
        end
        StUpdate: begin
          state_q  <= StIdle;
          x_q      <= x_d;
          y_q      <= y_d;
          dir_q    <= key_dir;
          moving_q <= key_valid;
          if (key_valid) begin
            if (anim_cnt_q == AnimLast) begin
              anim_cnt_q <= '0;
              anim_q     <= anim_q + 2'd1;
            end else begin
              anim_cnt_q <= anim_cnt_q + AnimW'(1);
            end
          end else begin
            anim_cnt_q <= '0;
            anim_q     <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ShooterX   = x_q;
  assign ShooterY   = y_q;
  assign ShooterDir = dir_q;
  assign moving     = moving_q;
  assign anim_idx   = anim_q;

endmodule
